riscv_mem_port_arbiter: RTL and testbench

//  Shares one memory port between instruction fetch (I) and the data memory

---
 rtl/riscv_mem_port_arbiter_pkg.sv | 20 ++
 rtl/riscv_mem_port_arbiter_if.sv | 49 ++++
 rtl/riscv_mem_port_arbiter_prio.sv | 28 ++
 rtl/riscv_mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package riscv_mem_port_arbiter_pkg;

    localparam logic [1:0] Byte_Access     = 2'b00;
    localparam logic [1:0] Halfword_Access = 2'b01;
    localparam logic [1:0] Reserved_Access = 2'b10;
    localparam logic [1:0] Word_Access     = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_REQ  = 2'b01,
        ARB_RSP  = 2'b10
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/riscv_mem_port_arbiter_if.sv
// Bundle of fetch, data and unified-memory signals around the arbiter.
interface riscv_mem_port_arbiter_if;

    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;

    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic [1:0]  d_byte_en_i;
    logic        d_wr_i;
    logic [31:0] d_wr_data_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [1:0]  mem_byte_en_o;
    logic        mem_wr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rd_data_i;

    // Arbiter side
    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_addr_i, d_byte_en_i, d_wr_i, d_wr_data_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rd_data_i
    );

    // Requesters plus memory
    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_addr_i, d_byte_en_i, d_wr_i, d_wr_data_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rd_data_i
    );

endinterface

// File: rtl/riscv_mem_port_arbiter_prio.sv
// Combinational winner pick: D by default, I once D has won MAX_D_STREAK times in a row.
module riscv_mem_port_arbiter_prio
    import riscv_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned STREAK_W     = 3
) (
    input  logic                i_d_req,
    input  logic                i_i_req,
    input  logic [STREAK_W-1:0] i_streak,
    output arb_owner_e          o_owner,
    output logic                o_valid
);

    // Pick the owner of the next transaction
    always_comb begin
        o_valid = i_d_req | i_i_req;
        o_owner = OWN_I;
        if (i_i_req && (!i_d_req || (i_streak == STREAK_W'(MAX_D_STREAK)))) begin
            o_owner = OWN_I;
        end else if (i_d_req) begin
            o_owner = OWN_D;
        end else begin
            o_owner = OWN_I;
        end
    end

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses,
// one outstanding transaction at a time (IDLE -> REQ -> RSP).
module riscv_mem_port_arbiter
    import riscv_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned RSP_TIMEOUT  = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    riscv_mem_port_arbiter_if.slave  bus
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [1:0]  ST_IDLE  = 2'(ARB_IDLE);
    localparam logic [1:0]  ST_REQ   = 2'(ARB_REQ);
    localparam logic [1:0]  ST_RSP   = 2'(ARB_RSP);

    logic [1:0]          r_state;
    arb_owner_e          r_owner;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic [1:0]          r_mem_byte_en;
    logic                r_mem_wr;
    logic [31:0]         r_mem_wr_data;
    logic [STREAK_W-1:0] r_streak;
    logic [7:0]          r_tmo_cnt;

    arb_owner_e          w_owner;
    logic                w_valid;
    logic                w_arb;
    logic                w_in_rsp;
    logic                w_timeout;
    logic                w_rsp_done;

    riscv_mem_port_arbiter_prio #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .STREAK_W     (STREAK_W)
    ) u_prio (
        .i_d_req  (bus.d_req_i),
        .i_i_req  (bus.i_req_i),
        .i_streak (r_streak),
        .o_owner  (w_owner),
        .o_valid  (w_valid)
    );

    assign w_arb      = (r_state == ST_IDLE) && w_valid;
    assign w_in_rsp   = (r_state == ST_RSP);
    assign w_timeout  = w_in_rsp && !bus.mem_rvalid_i && (r_tmo_cnt == 8'(RSP_TIMEOUT));
    assign w_rsp_done = w_in_rsp && (bus.mem_rvalid_i || w_timeout);

    // Grant and response are same-cycle by protocol, so these stay combinational
    assign bus.i_gnt_o    = w_arb && (w_owner == OWN_I);
    assign bus.d_gnt_o    = w_arb && (w_owner == OWN_D);
    assign bus.i_rvalid_o = w_rsp_done && (r_owner == OWN_I);
    assign bus.d_rvalid_o = w_rsp_done && (r_owner == OWN_D);
    assign bus.d_err_o    = w_timeout;
    assign bus.i_rdata_o  = (w_in_rsp && bus.mem_rvalid_i && (r_owner == OWN_I))
                            ? bus.mem_rd_data_i : 32'h0000_0000;
    assign bus.d_rdata_o  = (w_in_rsp && bus.mem_rvalid_i && (r_owner == OWN_D) && !r_mem_wr)
                            ? bus.mem_rd_data_i : 32'h0000_0000;

    assign bus.mem_req_o     = r_mem_req;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.mem_byte_en_o = r_mem_byte_en;
    assign bus.mem_wr_o      = r_mem_wr;
    assign bus.mem_wr_data_o = r_mem_wr_data;

    // Transaction FSM and latched request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_I;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'h0000_0000;
            r_mem_byte_en <= 2'b00;
            r_mem_wr      <= 1'b0;
            r_mem_wr_data <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state   <= ST_REQ;
                        r_owner   <= w_owner;
                        r_mem_req <= 1'b1;
                        if (w_owner == OWN_D) begin
                            r_mem_addr    <= bus.d_addr_i;
                            r_mem_byte_en <= bus.d_byte_en_i;
                            r_mem_wr      <= bus.d_wr_i;
                            r_mem_wr_data <= bus.d_wr_data_i;
                        end else begin
                            r_mem_addr    <= bus.i_addr_i;
                            r_mem_byte_en <= Word_Access;
                            r_mem_wr      <= 1'b0;
                            r_mem_wr_data <= 32'h0000_0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt_i) begin
                        r_state   <= ST_RSP;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (w_rsp_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Consecutive D wins while I waits; any other arbitration outcome clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_streak <= '0;
        end else if (w_arb) begin
            if ((w_owner == OWN_D) && bus.i_req_i) begin
                if (r_streak != STREAK_W'(MAX_D_STREAK)) begin
                    r_streak <= r_streak + STREAK_W'(1);
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

    // Response watchdog: counts cycles spent in RSP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= 8'h00;
        end else if (w_in_rsp && !w_rsp_done) begin
            r_tmo_cnt <= r_tmo_cnt + 8'h01;
        end else begin
            r_tmo_cnt <= 8'h00;
        end
    end

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed bench for riscv_mem_port_arbiter: fetch/data arbitration, stores, timeout, reset.
module tb_riscv_mem_port_arbiter;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    riscv_mem_port_arbiter_if bus_if ();

    riscv_mem_port_arbiter #(
        .MAX_D_STREAK (4),
        .RSP_TIMEOUT  (255)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus_if.i_req_i       = 1'b0;
        bus_if.i_addr_i      = 32'h0;
        bus_if.d_req_i       = 1'b0;
        bus_if.d_addr_i      = 32'h0;
        bus_if.d_byte_en_i   = 2'b00;
        bus_if.d_wr_i        = 1'b0;
        bus_if.d_wr_data_i   = 32'h0;
        bus_if.mem_gnt_i     = 1'b0;
        bus_if.mem_rvalid_i  = 1'b0;
        bus_if.mem_rd_data_i = 32'h0;
    endtask

    // Called at the first REQ negedge: hold off mem_gnt for w cycles, grant, then respond.
    task automatic serve(input int w, input logic [31:0] data);
        repeat (w) @(negedge clk);
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i     = 1'b0;
        bus_if.mem_rvalid_i  = 1'b1;
        bus_if.mem_rd_data_i = data;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk); #1;
        n_tests++; if (bus_if.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", bus_if.mem_req_o); end
        n_tests++; if (bus_if.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", bus_if.mem_addr_o); end
        n_tests++; if ({bus_if.i_gnt_o, bus_if.d_gnt_o, bus_if.i_rvalid_o, bus_if.d_rvalid_o, bus_if.d_err_o} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus_if.i_gnt_o, bus_if.d_gnt_o, bus_if.i_rvalid_o, bus_if.d_rvalid_o, bus_if.d_err_o}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_i_only();
        @(negedge clk);
        bus_if.i_req_i  = 1'b1;
        bus_if.i_addr_i = 32'h0000_0100;
        #1;
        n_tests++; if (bus_if.i_gnt_o !== 1'b1 || bus_if.d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL i_only_gnt: got i=%b d=%b expected i=1 d=0", bus_if.i_gnt_o, bus_if.d_gnt_o); end
        @(negedge clk);
        bus_if.i_req_i = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL i_only_mem_req: got %b expected 1", bus_if.mem_req_o); end
        n_tests++; if (bus_if.mem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL i_only_addr: got %h expected 00000100", bus_if.mem_addr_o); end
        n_tests++; if (bus_if.mem_byte_en_o !== 2'b11 || bus_if.mem_wr_o !== 1'b0) begin n_fail++; $display("FAIL i_only_be_wr: got be=%b wr=%b expected be=11 wr=0", bus_if.mem_byte_en_o, bus_if.mem_wr_o); end
        n_tests++; if (bus_if.i_gnt_o !== 1'b0) begin n_fail++; $display("FAIL i_only_gnt_pulse: got %b expected 0", bus_if.i_gnt_o); end
        serve(2, 32'hDEAD_BEEF);
        n_tests++; if (bus_if.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL i_only_req_drop: got %b expected 0", bus_if.mem_req_o); end
        n_tests++; if (bus_if.i_rvalid_o !== 1'b1 || bus_if.i_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL i_only_rsp: got v=%b d=%h expected v=1 d=deadbeef", bus_if.i_rvalid_o, bus_if.i_rdata_o); end
        n_tests++; if (bus_if.d_rvalid_o !== 1'b0 || bus_if.d_rdata_o !== 32'h0 || bus_if.d_err_o !== 1'b0) begin n_fail++; $display("FAIL i_only_d_silent: got v=%b d=%h e=%b expected 0", bus_if.d_rvalid_o, bus_if.d_rdata_o, bus_if.d_err_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        #1;
        n_tests++; if (bus_if.i_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL i_only_rvalid_pulse: got %b expected 0", bus_if.i_rvalid_o); end
    endtask

    task automatic test_i_and_d();
        bus_if.i_req_i     = 1'b1;
        bus_if.i_addr_i    = 32'h0000_0200;
        bus_if.d_req_i     = 1'b1;
        bus_if.d_addr_i    = 32'h0000_2003;
        bus_if.d_byte_en_i = 2'b00;
        bus_if.d_wr_i      = 1'b0;
        #1;
        n_tests++; if (bus_if.d_gnt_o !== 1'b1 || bus_if.i_gnt_o !== 1'b0) begin n_fail++; $display("FAIL both_d_first: got i=%b d=%b expected i=0 d=1", bus_if.i_gnt_o, bus_if.d_gnt_o); end
        @(negedge clk);
        bus_if.d_req_i = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_addr_o !== 32'h0000_2003 || bus_if.mem_byte_en_o !== 2'b00) begin n_fail++; $display("FAIL both_d_addr: got %h/%b expected 00002003/00", bus_if.mem_addr_o, bus_if.mem_byte_en_o); end
        serve(0, 32'h1122_3344);
        n_tests++; if (bus_if.d_rvalid_o !== 1'b1 || bus_if.d_rdata_o !== 32'h1122_3344 || bus_if.i_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL both_d_rsp: got dv=%b d=%h iv=%b expected 1/11223344/0", bus_if.d_rvalid_o, bus_if.d_rdata_o, bus_if.i_rvalid_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        #1;
        n_tests++; if (bus_if.i_gnt_o !== 1'b1) begin n_fail++; $display("FAIL both_i_next: got %b expected 1", bus_if.i_gnt_o); end
        @(negedge clk);
        bus_if.i_req_i = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_addr_o !== 32'h0000_0200 || bus_if.mem_byte_en_o !== 2'b11) begin n_fail++; $display("FAIL both_i_addr: got %h/%b expected 00000200/11", bus_if.mem_addr_o, bus_if.mem_byte_en_o); end
        serve(1, 32'hCAFE_F00D);
        n_tests++; if (bus_if.i_rvalid_o !== 1'b1 || bus_if.i_rdata_o !== 32'hCAFE_F00D || bus_if.d_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL both_i_rsp: got iv=%b d=%h dv=%b expected 1/cafef00d/0", bus_if.i_rvalid_o, bus_if.i_rdata_o, bus_if.d_rvalid_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
    endtask

    task automatic test_d_streak();
        logic exp_i;
        bus_if.i_req_i     = 1'b1;
        bus_if.i_addr_i    = 32'h0000_0300;
        bus_if.d_req_i     = 1'b1;
        bus_if.d_addr_i    = 32'h0000_0400;
        bus_if.d_byte_en_i = 2'b11;
        bus_if.d_wr_i      = 1'b0;
        for (int g = 0; g < 5; g++) begin
            exp_i = (g == 4);
            #1;
            n_tests++; if (bus_if.i_gnt_o !== exp_i || bus_if.d_gnt_o !== !exp_i) begin
                n_fail++; $display("FAIL streak_grant%0d: got i=%b d=%b expected i=%b d=%b", g, bus_if.i_gnt_o, bus_if.d_gnt_o, exp_i, !exp_i); end
            @(negedge clk);
            if (exp_i) bus_if.i_req_i = 1'b0;
            serve(0, 32'h0000_1000 + g);
            n_tests++; if (bus_if.i_rvalid_o !== exp_i || bus_if.d_rvalid_o !== !exp_i) begin
                n_fail++; $display("FAIL streak_rsp%0d: got i=%b d=%b expected i=%b d=%b", g, bus_if.i_rvalid_o, bus_if.d_rvalid_o, exp_i, !exp_i); end
            @(negedge clk);
            bus_if.mem_rvalid_i = 1'b0;
        end
        // Streak must have cleared: with I pending again D wins the next round
        bus_if.i_req_i = 1'b1;
        #1;
        n_tests++; if (bus_if.d_gnt_o !== 1'b1 || bus_if.i_gnt_o !== 1'b0) begin n_fail++; $display("FAIL streak_cleared: got i=%b d=%b expected i=0 d=1", bus_if.i_gnt_o, bus_if.d_gnt_o); end
        @(negedge clk);
        bus_if.d_req_i = 1'b0;
        serve(0, 32'h0);
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        #1;
        n_tests++; if (bus_if.i_gnt_o !== 1'b1) begin n_fail++; $display("FAIL streak_i_after: got %b expected 1", bus_if.i_gnt_o); end
        @(negedge clk);
        bus_if.i_req_i = 1'b0;
        serve(0, 32'h0);
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
    endtask

    task automatic test_d_store();
        bus_if.d_req_i     = 1'b1;
        bus_if.d_addr_i    = 32'h0000_0040;
        bus_if.d_byte_en_i = 2'b01;
        bus_if.d_wr_i      = 1'b1;
        bus_if.d_wr_data_i = 32'h0000_0055;
        #1;
        n_tests++; if (bus_if.d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL store_gnt: got %b expected 1", bus_if.d_gnt_o); end
        @(negedge clk);
        bus_if.d_req_i = 1'b0;
        bus_if.d_wr_i  = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_wr_o !== 1'b1 || bus_if.mem_wr_data_o !== 32'h0000_0055) begin n_fail++; $display("FAIL store_wr: got wr=%b data=%h expected 1/00000055", bus_if.mem_wr_o, bus_if.mem_wr_data_o); end
        n_tests++; if (bus_if.mem_addr_o !== 32'h0000_0040 || bus_if.mem_byte_en_o !== 2'b01) begin n_fail++; $display("FAIL store_addr: got %h/%b expected 00000040/01", bus_if.mem_addr_o, bus_if.mem_byte_en_o); end
        serve(0, 32'hFFFF_FFFF);
        n_tests++; if (bus_if.d_rvalid_o !== 1'b1 || bus_if.d_rdata_o !== 32'h0 || bus_if.d_err_o !== 1'b0) begin
            n_fail++; $display("FAIL store_rsp: got v=%b d=%h e=%b expected 1/00000000/0", bus_if.d_rvalid_o, bus_if.d_rdata_o, bus_if.d_err_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc;
        bus_if.d_req_i     = 1'b1;
        bus_if.d_addr_i    = 32'h0000_0080;
        bus_if.d_byte_en_i = 2'b11;
        @(negedge clk);
        bus_if.d_req_i   = 1'b0;
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        cyc = 1;
        #1;
        while (bus_if.d_rvalid_o !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        n_tests++; if (cyc !== 256) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 256", cyc); end
        n_tests++; if (bus_if.d_err_o !== 1'b1 || bus_if.d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL timeout_err: got e=%b d=%h expected 1/00000000", bus_if.d_err_o, bus_if.d_rdata_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i  = 1'b1;
        bus_if.mem_rd_data_i = 32'h1234_5678;
        #1;
        n_tests++; if (bus_if.d_rvalid_o !== 1'b0 || bus_if.d_err_o !== 1'b0 || bus_if.mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_late_drop: got v=%b e=%b req=%b expected 000", bus_if.d_rvalid_o, bus_if.d_err_o, bus_if.mem_req_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid_rsp();
        bus_if.d_req_i     = 1'b1;
        bus_if.d_addr_i    = 32'h0000_0500;
        bus_if.d_byte_en_i = 2'b10;
        @(negedge clk);
        bus_if.d_req_i   = 1'b0;
        bus_if.mem_gnt_i = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_addr_o !== 32'h0 || bus_if.mem_byte_en_o !== 2'b00 || bus_if.mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got addr=%h be=%b req=%b expected 0", bus_if.mem_addr_o, bus_if.mem_byte_en_o, bus_if.mem_req_o); end
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.mem_rvalid_i  = 1'b1;
        bus_if.mem_rd_data_i = 32'hA5A5_A5A5;
        #1;
        n_tests++; if ({bus_if.i_rvalid_o, bus_if.d_rvalid_o, bus_if.d_err_o} !== 3'b000 || bus_if.d_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_late_drop: got %b/%h expected 000/00000000", {bus_if.i_rvalid_o, bus_if.d_rvalid_o, bus_if.d_err_o}, bus_if.d_rdata_o); end
        @(negedge clk);
        bus_if.mem_rvalid_i = 1'b0;
        #1;
        n_tests++; if (bus_if.mem_req_o !== 1'b0 || bus_if.d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got req=%b gnt=%b expected 0", bus_if.mem_req_o, bus_if.d_gnt_o); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_i_only();
        test_i_and_d();
        test_d_streak();
        test_d_store();
        test_timeout();
        test_reset_mid_rsp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
